// File: rtl/affine_batch_engine_if.sv
// Bus bundle for affine_batch_engine (TinyQV peripheral bus).
//   master: the bus host (CPU / testbench) driving address, data and strobes.
//   slave : the peripheral, returning combinational read data, ready and the
//           level interrupt.
interface affine_batch_engine_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready, user_interrupt
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready, user_interrupt
    );
endinterface

// File: rtl/affine_batch_engine.sv
// affine_batch_engine: streaming 2-D affine transform peripheral.
//   x' = sat((A*x >>> FRAC) + (B*y >>> FRAC) + TX)
//   y' = sat((D*x >>> FRAC) + (E*y >>> FRAC) + TY)
// Input pairs and results are buffered in DEPTH-entry FIFOs; a single shared
// WIDTH x WIDTH signed multiplier is time-multiplexed by the engine FSM.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : peripheral bus (slave modport): address, data_in, data_write_n,
//           data_read_n, data_out (combinational), data_ready (always 1),
//           user_interrupt (level, threshold on output FIFO occupancy)
module affine_batch_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    affine_batch_engine_if.slave bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + 2;

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_P0, S_P1, S_P2, S_P3, S_STORE} state_t;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > MAX_V)      return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < MIN_V) return {1'b1, {(WIDTH-1){1'b0}}};
        else                return v[WIDTH-1:0];
    endfunction

    function automatic logic clamps(input logic signed [ACC_W-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    function automatic logic [31:0] sext32(input logic signed [WIDTH-1:0] v);
        return {{(32-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    state_t state, state_nxt;

    logic en, irq_en;
    logic signed [WIDTH-1:0] coef_a, coef_b, coef_d, coef_e, coef_tx, coef_ty, pend_x;
    logic [7:0] thresh;
    logic ovf, unf, satf;

    logic signed [WIDTH-1:0] in_x_mem [DEPTH];
    logic signed [WIDTH-1:0] in_y_mem [DEPTH];
    logic signed [WIDTH-1:0] out_x_mem [DEPTH];
    logic signed [WIDTH-1:0] out_y_mem [DEPTH];
    logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
    logic [CW-1:0] in_cnt, out_cnt;

    logic signed [WIDTH-1:0] x_r, y_r, mul_a, mul_b, res_x, res_y;
    logic signed [PROD_W-1:0] prod, prod_shr;
    logic signed [ACC_W-1:0] prod_sh, acc_x, acc_y, sum_x, sum_y;

    logic wr, rd, clear, wr_ctrl, wr_status, wr_yin, rd_yout;
    logic in_push, in_pop, out_push, out_pop, ovf_set, unf_set, sat_set;
    logic unused_bits;

    assign wr        = bus.data_write_n != 2'b11;
    assign rd        = bus.data_read_n != 2'b11;
    assign wr_ctrl   = wr && bus.address == 6'h00;
    assign wr_status = wr && bus.address == 6'h04;
    assign wr_yin    = wr && bus.address == 6'h24;
    assign rd_yout   = rd && bus.address == 6'h2C;
    // Clear is an action, not state: it overrides every other update this cycle.
    assign clear     = wr_ctrl && bus.data_in[2];

    // The full check uses the registered count, so a push to a full FIFO is
    // dropped even if the engine pops in the same cycle.
    assign in_push  = wr_yin && in_cnt != CW'(DEPTH) && !clear;
    assign ovf_set  = wr_yin && in_cnt == CW'(DEPTH);
    assign in_pop   = state == S_LOAD && !clear;
    assign out_push = state == S_STORE && !clear;
    assign out_pop  = rd_yout && out_cnt != '0 && !clear;
    assign unf_set  = rd_yout && out_cnt == '0;

    // Shared multiplier: operand pair selected by the current product state;
    // coefficients are taken live so a mid-computation rewrite only affects
    // products not yet formed.
    always_comb begin
        mul_a = coef_a;
        mul_b = x_r;
        case (state)
            S_P1:    begin mul_a = coef_b; mul_b = y_r; end
            S_P2:    begin mul_a = coef_d; mul_b = x_r; end
            S_P3:    begin mul_a = coef_e; mul_b = y_r; end
            default: ;
        endcase
    end

    assign prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign prod_shr = prod >>> FRAC;
    assign prod_sh  = {{(ACC_W-PROD_W){prod_shr[PROD_W-1]}}, prod_shr};
    assign sum_x    = acc_x + {{(ACC_W-WIDTH){coef_tx[WIDTH-1]}}, coef_tx};
    assign sum_y    = acc_y + {{(ACC_W-WIDTH){coef_ty[WIDTH-1]}}, coef_ty};
    assign res_x    = sat(sum_x);
    assign res_y    = sat(sum_y);
    assign sat_set  = out_push && (clamps(sum_x) || clamps(sum_y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && in_cnt != '0 && out_cnt < CW'(DEPTH)) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_P0;
            S_P0:    state_nxt = S_P1;
            S_P1:    state_nxt = S_P2;
            S_P2:    state_nxt = S_P3;
            S_P3:    state_nxt = S_STORE;
            S_STORE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    // Register file, FIFO pointers/counts and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= 1'b0; irq_en <= 1'b0; thresh <= '0; pend_x <= '0;
            coef_a <= '0; coef_b <= '0; coef_d <= '0; coef_e <= '0;
            coef_tx <= '0; coef_ty <= '0;
            ovf <= 1'b0; unf <= 1'b0; satf <= 1'b0;
            in_wp <= '0; in_rp <= '0; in_cnt <= '0;
            out_wp <= '0; out_rp <= '0; out_cnt <= '0;
        end else begin
            if (wr_ctrl && !bus.data_in[2]) {irq_en, en} <= bus.data_in[1:0];
            if (wr) begin
                case (bus.address)
                    6'h08: coef_a  <= bus.data_in[WIDTH-1:0];
                    6'h0C: coef_b  <= bus.data_in[WIDTH-1:0];
                    6'h10: coef_d  <= bus.data_in[WIDTH-1:0];
                    6'h14: coef_e  <= bus.data_in[WIDTH-1:0];
                    6'h18: coef_tx <= bus.data_in[WIDTH-1:0];
                    6'h1C: coef_ty <= bus.data_in[WIDTH-1:0];
                    6'h20: pend_x  <= bus.data_in[WIDTH-1:0];
                    6'h30: thresh  <= bus.data_in[7:0];
                    default: ;
                endcase
            end
            if (clear) begin
                ovf <= 1'b0; unf <= 1'b0; satf <= 1'b0;
                in_wp <= '0; in_rp <= '0; in_cnt <= '0;
                out_wp <= '0; out_rp <= '0; out_cnt <= '0;
            end else begin
                ovf  <= (ovf  && !(wr_status && bus.data_in[17])) || ovf_set;
                unf  <= (unf  && !(wr_status && bus.data_in[18])) || unf_set;
                satf <= (satf && !(wr_status && bus.data_in[19])) || sat_set;
                if (in_push)  in_wp  <= in_wp + 1'b1;
                if (in_pop)   in_rp  <= in_rp + 1'b1;
                if (out_push) out_wp <= out_wp + 1'b1;
                if (out_pop)  out_rp <= out_rp + 1'b1;
                in_cnt  <= in_cnt + CW'(in_push) - CW'(in_pop);
                out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
            end
        end
    end

    // FIFO storage and datapath registers carry no reset: they are only
    // observable through the counts, which are reset.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_x_mem[in_wp] <= pend_x;
            in_y_mem[in_wp] <= bus.data_in[WIDTH-1:0];
        end
        if (out_push) begin
            out_x_mem[out_wp] <= res_x;
            out_y_mem[out_wp] <= res_y;
        end
        case (state)
            S_LOAD:  begin x_r <= in_x_mem[in_rp]; y_r <= in_y_mem[in_rp]; end
            S_P0:    acc_x <= prod_sh;
            S_P1:    acc_x <= acc_x + prod_sh;
            S_P2:    acc_y <= prod_sh;
            S_P3:    acc_y <= acc_y + prod_sh;
            default: ;
        endcase
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            6'h00: bus.data_out = {30'd0, irq_en, en};
            6'h04: bus.data_out = {12'd0, satf, unf, ovf, state != S_IDLE, 8'(out_cnt), 8'(in_cnt)};
            6'h08: bus.data_out = sext32(coef_a);
            6'h0C: bus.data_out = sext32(coef_b);
            6'h10: bus.data_out = sext32(coef_d);
            6'h14: bus.data_out = sext32(coef_e);
            6'h18: bus.data_out = sext32(coef_tx);
            6'h1C: bus.data_out = sext32(coef_ty);
            6'h28: if (out_cnt != '0) bus.data_out = sext32(out_x_mem[out_rp]);
            6'h2C: if (out_cnt != '0) bus.data_out = sext32(out_y_mem[out_rp]);
            6'h30: bus.data_out = {24'd0, thresh};
            default: ;
        endcase
    end

    assign bus.data_ready     = 1'b1;
    assign bus.user_interrupt = irq_en && thresh != 8'd0 && 8'(out_cnt) >= thresh;
    assign unused_bits        = ^{bus.data_in[31:20], bus.data_in[16:WIDTH]};
endmodule

// File: tb/tb_affine_batch_engine.sv
// Self-checking bench for affine_batch_engine: directed scenarios plus
// randomized batches, with expected results queued at push time and compared
// by an independent bus monitor whenever XOUT/YOUT is read.
module tb_affine_batch_engine;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int DEPTH = 4;

    localparam logic [5:0] A_CTRL = 6'h00, A_ST = 6'h04, A_A = 6'h08, A_B = 6'h0C,
                           A_D = 6'h10, A_E = 6'h14, A_TX = 6'h18, A_TY = 6'h1C,
                           A_XIN = 6'h20, A_YIN = 6'h24, A_XOUT = 6'h28, A_YOUT = 6'h2C,
                           A_TH = 6'h30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    affine_batch_engine_if bus();

    affine_batch_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    typedef struct { int x; int y; } pair_t;
    pair_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int ca, cb, cd, ce, ctx, cty;
    bit sat_seen;
    logic last_irq;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: floor division and clamping in plain integer arithmetic.
    function automatic longint floor_div(input longint p);
        longint d, q;
        d = longint'(1) << FRAC;
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clip(input longint v, inout bit s);
        longint hi, lo;
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
        if (v > hi) begin s = 1; return int'(hi); end
        if (v < lo) begin s = 1; return int'(lo); end
        return int'(v);
    endfunction

    function automatic pair_t model(input int x, input int y);
        pair_t r;
        r.x = clip(floor_div(longint'(ca) * x) + floor_div(longint'(cb) * y) + ctx, sat_seen);
        r.y = clip(floor_div(longint'(cd) * x) + floor_div(longint'(ce) * y) + cty, sat_seen);
        return r;
    endfunction

    // Each bus task starts at a falling edge and returns at the next one.
    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus.address = a;
        bus.data_in = d;
        bus.data_write_n = 2'b00;
        @(negedge clk);
        bus.data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        bus.address = a;
        bus.data_read_n = 2'b00;
        #3;
        d = bus.data_out;
        last_irq = bus.user_interrupt;
        @(negedge clk);
        bus.data_read_n = 2'b11;
    endtask

    task automatic set_coefs(input int a, input int b, input int d, input int e,
                             input int tx, input int ty);
        ca = a; cb = b; cd = d; ce = e; ctx = tx; cty = ty;
        wr(A_A, a); wr(A_B, b); wr(A_D, d); wr(A_E, e); wr(A_TX, tx); wr(A_TY, ty);
    endtask

    task automatic push(input int x, input int y, input bit accept);
        wr(A_XIN, x);
        if (accept) exp_q.push_back(model(x, y));
        wr(A_YIN, y);
    endtask

    task automatic wait_out(input int n, input int budget, input string nm);
        logic [31:0] s;
        int k;
        k = 0;
        rd(A_ST, s);
        while (int'(s[15:8]) != n && k < budget) begin
            rd(A_ST, s);
            k++;
        end
        check(nm, 32'(s[15:8]), 32'(n));
    endtask

    task automatic drain(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            rd(A_XOUT, d);
            rd(A_YOUT, d);
        end
    endtask

    // Monitor: every XOUT/YOUT read is compared with the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst_n && bus.data_read_n != 2'b11) begin
            if (bus.address == A_XOUT) begin
                check("xout", bus.data_out, exp_q.size() != 0 ? exp_q[0].x : 0);
            end else if (bus.address == A_YOUT) begin
                if (exp_q.size() != 0) begin
                    check("yout", bus.data_out, exp_q[0].y);
                    void'(exp_q.pop_front());
                end else begin
                    check("yout_empty", bus.data_out, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d;
        logic [31:0] st [1:8];
        int n;

        bus.address = '0;
        bus.data_in = '0;
        bus.data_write_n = 2'b11;
        bus.data_read_n = 2'b11;
        ca = 0; cb = 0; cd = 0; ce = 0; ctx = 0; cty = 0;
        sat_seen = 0;
        repeat (3) @(negedge clk);

        // Reset state
        rd(A_ST, s);      check("reset_status", s, 32'd0);
        check("reset_ready", 32'(bus.data_ready), 32'd1);
        check("reset_irq", 32'(bus.user_interrupt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_A, s);       check("reset_coef_a", s, 32'd0);

        // Identity + translate, with cycle-exact latency
        set_coefs(32'h100, 0, 0, 32'h100, 5, -3);
        rd(A_TY, s);      check("ty_readback", s, 32'hFFFF_FFFD);
        wr(A_CTRL, 32'h1);
        push(10, 20, 1);
        for (int i = 1; i <= 8; i++) rd(A_ST, st[i]);
        check("t1_in_count", 32'(st[1][7:0]), 32'd1);
        check("t1_busy", 32'(st[1][16]), 32'd0);
        check("t2_busy", 32'(st[2][16]), 32'd1);
        check("t7_out_count", 32'(st[7][15:8]), 32'd0);
        check("t8_out_count", 32'(st[8][15:8]), 32'd1);
        drain(1);
        rd(A_ST, s);      check("id_out_count_after_pop", 32'(s[15:8]), 32'd0);

        // Rotation/scale and floor behaviour
        set_coefs(0, -256, 32'h100, 0, 0, 0);
        rd(A_B, s);       check("b_readback", s, 32'hFFFF_FF00);
        push(3, 7, 1);
        wait_out(1, 30, "rot_wait");
        drain(1);
        ca = 32'h80; wr(A_A, 32'h80);
        push(-1, 0, 1);
        wait_out(1, 30, "floor_wait");
        drain(1);

        // Saturation and W1C of the saturated flag
        set_coefs(32'h7FFF, 32'h7FFF, 0, 0, 0, 0);
        push(32'h7FFF, 32'h7FFF, 1);
        wait_out(1, 30, "sat_wait");
        drain(1);
        rd(A_ST, s);      check("sat_flag_set", 32'(s[19]), 32'd1);
        wr(A_ST, 32'h8_0000);
        rd(A_ST, s);      check("sat_flag_clr", 32'(s[19]), 32'd0);

        // Batch with overflow, then underflow
        wr(A_CTRL, 32'h0);
        set_coefs(32'h100, 32'h40, -32'h80, 32'h100, 1, 2);
        for (int i = 0; i < 5; i++) push(i * 17 - 30, 100 - i * 9, i < DEPTH);
        rd(A_ST, s);
        check("batch_in_count", 32'(s[7:0]), 32'(DEPTH));
        check("batch_overflow", 32'(s[17]), 32'd1);
        check("batch_out_idle", 32'(s[15:8]), 32'd0);
        wr(A_CTRL, 32'h1);
        wait_out(DEPTH, 80, "batch_wait");
        drain(DEPTH);
        rd(A_YOUT, d);
        rd(A_ST, s);      check("underflow_flag", 32'(s[18]), 32'd1);
        wr(A_ST, 32'h6_0000);
        rd(A_ST, s);      check("sticky_w1c", 32'(s[18:17]), 32'd0);

        // Threshold interrupt
        wr(A_TH, 32'd2);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) push(i + 1, -i, 1);
        wait_out(1, 30, "irq_wait1");  check("irq_at_1", 32'(last_irq), 32'd0);
        wait_out(2, 30, "irq_wait2");  check("irq_at_2", 32'(last_irq), 32'd1);
        wait_out(3, 30, "irq_wait3");
        rd(A_YOUT, d);
        rd(A_ST, s);      check("irq_after_pop1", 32'(last_irq), 32'd1);
        rd(A_YOUT, d);
        rd(A_ST, s);      check("irq_after_pop2", 32'(last_irq), 32'd0);
        drain(1);

        // Clear during P2 of the first of two queued pairs
        wr(A_CTRL, 32'h1);
        push(5, 6, 1);                 // YIN in cycle T
        push(7, 8, 1);                 // YIN in cycle T+2
        repeat (2) @(negedge clk);     // now at T+5
        wr(A_CTRL, 32'h5);
        exp_q.delete();
        rd(A_ST, s);
        check("clear_busy", 32'(s[16]), 32'd0);
        check("clear_counts", 32'(s[15:0]), 32'd0);
        repeat (10) @(negedge clk);
        rd(A_ST, s);      check("clear_no_output", 32'(s[15:0]), 32'd0);
        rd(A_CTRL, s);    check("clear_keeps_ctrl", s, 32'd1);

        // Randomized batches against the model
        for (int it = 0; it < 15; it++) begin
            sat_seen = 0;
            set_coefs($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                      $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                      $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++)
                push($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1);
            wait_out(n, 40, "rand_wait");
            drain(n);
            rd(A_ST, s);  check("rand_sat_flag", 32'(s[19]), 32'(sat_seen));
            wr(A_ST, 32'h8_0000);
        end

        // Asynchronous reset during P1
        set_coefs(32'h100, 0, 0, 32'h100, 0, 0);
        wr(A_TH, 32'd1);
        wr(A_CTRL, 32'h3);
        push(4, 9, 1);
        wait_out(1, 30, "pre_reset_wait");
        check("pre_reset_irq", 32'(last_irq), 32'd1);
        push(2, 3, 1);                 // YIN in cycle T
        repeat (3) @(negedge clk);     // now at T+4 (P1)
        rst_n = 1'b0;
        #1;
        check("rst_irq", 32'(bus.user_interrupt), 32'd0);
        check("rst_ready", 32'(bus.data_ready), 32'd1);
        rd(A_ST, s);      check("rst_status", s, 32'd0);
        rd(A_A, s);       check("rst_coef_a", s, 32'd0);
        rd(A_XOUT, s);    check("rst_xout", s, 32'd0);
        exp_q.delete();
        ca = 0; cb = 0; cd = 0; ce = 0; ctx = 0; cty = 0;
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_ST, s);      check("post_rst_status", s, 32'd0);
        rd(A_CTRL, s);    check("post_rst_ctrl", s, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/affine_batch_engine.md
# affine_batch_engine

Parametrised 2-D affine transform peripheral for the TinyQV peripheral bus, and the successor to the single-point transform block. It computes x' = (A·x + B·y) >> FRAC + TX and y' = (D·x + E·y) >> FRAC + TY on fixed-point samples. Input and output pairs are buffered in FIFOs so software can stream batches. Results are saturated, and a threshold interrupt is provided.

## Interface
Parameters:
- WIDTH, 16: signed sample/coefficient width (8..16).
- FRAC, 8: fractional bits of coefficients (0..WIDTH-1).
- DEPTH, 4: entries per FIFO (power of 2, 2..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- address  in  6  register byte address
- data_in  in  32  write data; bits [WIDTH-1:0] used for any write size
- data_write_n  in  2  11 = no write, else write
- data_read_n  in  2  11 = no read, else read
- data_out  out  32  combinational read data
- data_ready  out  1  constant 1
- user_interrupt  out  1  level interrupt

## Operation
Register map:
- 0x00 CTRL [0] enable, [1] irq_en, [2] clear. Clear is write-1, self-clearing, and is never stored.
- 0x04 STATUS, read-only except the sticky bits:
  - [7:0] in_count, [15:8] out_count, [16] busy
  - [17] in_overflow, [18] out_underflow, [19] saturated
  - A write of 1 clears each of bits 17–19.
- 0x08 A, 0x0C B, 0x10 D, 0x14 E, 0x18 TX, 0x1C TY: read/write, read back sign-extended.
- 0x20 XIN: write latches a pending x.
- 0x24 YIN: write pushes the pair {pending x, data} into the input FIFO.
- 0x28 XOUT: returns the head x with no pop.
- 0x2C YOUT: returns the head y; a read pops the output pair.
- 0x30 THRESH [7:0].
- Any other address reads 0.

Input and output FIFOs:
- Push to a full input FIFO: the pair is dropped and in_overflow is set.
- YOUT read when the output FIFO is empty: returns 0, sets out_underflow, no pop. XOUT/YOUT reads of an empty FIFO return 0.

Engine FSM, with one shared WIDTH×WIDTH signed multiplier:
- IDLE: moves to LOAD when enable=1, in_count≠0 and out_count<DEPTH.
- LOAD: pops the input FIFO and latches x, y.
- P0 computes A·x, P1 B·y, P2 D·x, P3 E·y. Products are 2·WIDTH bits and are accumulated.
- STORE: pushes {x', y'} to the output FIFO, then returns to IDLE.
- busy=1 in every state except IDLE.

Arithmetic:
- Each product is arithmetic-shifted right by FRAC (floor), then summed with the sign-extended TX/TY in full width (2·WIDTH+2 bits).
- The sum is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Any clamp sets the saturated flag.
- Coefficients are sampled live in each P-state. Rewriting them mid-computation affects only the remaining products.

Control behaviour:
- Deasserting enable mid-computation: the current pair completes; no new LOAD is started.
- Clear: both FIFOs are flushed, the sticky bits are cleared, the FSM goes to IDLE and any in-flight result is discarded. Coefficients, CTRL[1:0] and THRESH are kept.
- user_interrupt = irq_en & (THRESH≠0) & (out_count ≥ THRESH).
- Reset: all registers, FIFOs, flags and the FSM are zeroed; all outputs are 0 except data_ready=1.

## Timing
- A YIN write in cycle T puts in_count+1 on STATUS in T+1.
- With the engine IDLE and enabled:
  - IDLE in T+1, LOAD T+2, P0..P3 T+3..T+6, STORE T+7.
  - The result is visible at XOUT/YOUT in T+8.
- Throughput: one pair per 7 cycles.
- Simultaneous bus push and engine pop on the input FIFO: both occur and the count is unchanged. The same applies to an engine push and a bus pop on the output FIFO.
- A push to a full input FIFO is dropped even when the engine pops in the same cycle.
- A clear write in the same cycle as STORE wins: nothing is pushed.
- STATUS, XOUT and YOUT reflect the state at the start of the read cycle. A pop takes effect at the clock edge.
- FIFO pointers wrap modulo DEPTH. Count is tracked separately, so full vs empty is unambiguous.

## Test plan
- Identity + translate: A=E=0x0100, B=D=0, TX=5, TY=−3, push (10,20) -> XOUT=15, YOUT=17 in cycle T+8; out_count=1. After the YOUT read, out_count=0.
- Rotation/scale: A=0, B=0xFF00, D=0x0100, E=0, push (3,7) -> (−7,3). Push (−1,0) with A=0x0080 -> x'=−1 (floor).
- Saturation: A=B=0x7FFF, FRAC=8, push (0x7FFF,0x7FFF) -> x'=0x7FFF, saturated=1. Writing 1 to STATUS[19] clears it.
- Batch/overflow (DEPTH=4): enable=0, push 5 pairs -> in_count=4, in_overflow=1. Set enable -> 4 results in push order. Then read YOUT again -> returns 0, out_underflow=1.
- Interrupt: THRESH=2, irq_en=1, push 3 pairs -> user_interrupt rises when out_count reaches 2. One YOUT pop with out_count 3->2 keeps it high; the next pop lowers it.
- Clear/reset mid-op: write clear during P2 -> busy=0 next cycle, both counts 0, no output. Assert rst_n low during P1 -> every output 0, coefficients 0.
